// File: rtl/filt_n.sv
// filt_n - multi-channel glitch / debounce filter.
//
// Each of WIDTH channels drives a filtered level y[k]. y[k] changes only
// after DEPTH consecutive enabled samples of i[k] disagree with it. Any
// sample that agrees with y[k] restarts that channel's run. Edges where
// en=0 neither count toward a run nor break it, so the filter can run
// from a prescaled tick.
//
// Parameters:
//   WIDTH  number of independent channels (1..32)
//   DEPTH  consecutive disagreeing samples needed to change y (1..255)
//   INIT   reset / clear value of every y bit (1-bit, replicated)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     sample enable
//   clr    synchronous clear to the reset state (overrides en)
//   i      raw channel inputs, already synchronous to clk
//   y      filtered levels, registered
//   rise   one-cycle pulse when y[k] goes 0->1
//   fall   one-cycle pulse when y[k] goes 1->0
//
// Build option:
//   FILT_N_EDGE_EN  when defined, rise/fall are registered edge pulses that
//                   line up with the y change. When undefined, rise/fall
//                   are tied to 0 and no edge logic exists; the ports stay
//                   so instantiations are identical in both builds.

module filt_n #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 3,
   parameter bit INIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] i,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Run counter only has to reach DEPTH-1, so clog2(DEPTH) bits suffice.
   localparam int CW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

   logic [WIDTH-1:0] y_nxt;
   logic [CW-1:0]    cnt     [WIDTH];
   logic [CW-1:0]    cnt_nxt [WIDTH];

   // Per-channel next state for an enabled, non-cleared edge. clr and en=0
   // are handled in the register process so this stays purely per channel.
   always_comb begin
      y_nxt = y;
      for (int k = 0; k < WIDTH; k++) begin
         cnt_nxt[k] = cnt[k];
      end
      if (en) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (i[k] == y[k]) begin
               cnt_nxt[k] = '0;
            end else if (cnt[k] == CNT_LAST) begin
               y_nxt[k]   = i[k];
               cnt_nxt[k] = '0;
            end else begin
               cnt_nxt[k] = cnt[k] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y <= {WIDTH{INIT}};
         for (int k = 0; k < WIDTH; k++) begin
            cnt[k] <= '0;
         end
      end else if (clr) begin
         y <= {WIDTH{INIT}};
         for (int k = 0; k < WIDTH; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         y <= y_nxt;
         for (int k = 0; k < WIDTH; k++) begin
            cnt[k] <= cnt_nxt[k];
         end
      end
   end

`ifdef FILT_N_EDGE_EN
   // y_nxt differs from y only on the edge that completes a run, so the
   // difference is exactly the set of channels changing this edge.
   logic [WIDTH-1:0] flip;
   assign flip = y_nxt ^ y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise <= '0;
         fall <= '0;
      end else if (clr) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= flip & y_nxt;
         fall <= flip & ~y_nxt;
      end
   end
`else
   assign rise = '0;
   assign fall = '0;
`endif

endmodule

// File: tb/tb_filt_n.sv
module tb_filt_n;

`ifdef FILT_N_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic [3:0] i3, i1, i255;
   logic [3:0] y3, rise3, fall3;
   logic [3:0] y1, rise1, fall1;
   logic [3:0] y255, rise255, fall255;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   filt_n #(.WIDTH(4), .DEPTH(3), .INIT(1'b0)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i(i3),
      .y(y3), .rise(rise3), .fall(fall3));

   filt_n #(.WIDTH(4), .DEPTH(1), .INIT(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i(i1),
      .y(y1), .rise(rise1), .fall(fall1));

   filt_n #(.WIDTH(4), .DEPTH(255), .INIT(1'b0)) u255 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i(i255),
      .y(y255), .rise(rise255), .fall(fall255));

   typedef struct {
      logic       en;
      logic       clr;
      logic [3:0] i;
      logic [3:0] y;
      logic [3:0] r;
      logic [3:0] f;
   } vec_t;

   localparam int NV = 35;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic e, input logic c, input logic [3:0] iv,
                               input logic [3:0] yv, input logic [3:0] rv,
                               input logic [3:0] fv);
      vec_t v;
      v.en = e; v.clr = c; v.i = iv; v.y = yv; v.r = rv; v.f = fv;
      return v;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected edge pulses only exist in the edge-enabled build.
   function automatic logic [3:0] em(input logic [3:0] v);
      return EDGE ? v : 4'h0;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rows: en, clr, i, expected y, rise, fall (rise/fall as in edge build)
      tbl[0]  = mk(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
      tbl[1]  = mk(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
      tbl[2]  = mk(1, 0, 4'hF, 4'hF, 4'hF, 4'h0);
      tbl[3]  = mk(1, 0, 4'h0, 4'hF, 4'h0, 4'h0);
      tbl[4]  = mk(1, 0, 4'h0, 4'hF, 4'h0, 4'h0);
      tbl[5]  = mk(1, 0, 4'hF, 4'hF, 4'h0, 4'h0);
      tbl[6]  = mk(1, 0, 4'h0, 4'hF, 4'h0, 4'h0);
      tbl[7]  = mk(1, 0, 4'h0, 4'hF, 4'h0, 4'h0);
      tbl[8]  = mk(1, 0, 4'h0, 4'h0, 4'h0, 4'hF);
      tbl[9]  = mk(1, 0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[10] = mk(1, 0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[11] = mk(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[12] = mk(1, 0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[13] = mk(1, 0, 4'h1, 4'h0, 4'h0, 4'h0);
      tbl[14] = mk(1, 0, 4'h1, 4'h1, 4'h1, 4'h0);
      tbl[15] = mk(1, 0, 4'h1, 4'h1, 4'h0, 4'h0);
      tbl[16] = mk(1, 0, 4'h3, 4'h1, 4'h0, 4'h0);
      tbl[17] = mk(0, 0, 4'h3, 4'h1, 4'h0, 4'h0);
      tbl[18] = mk(0, 0, 4'h3, 4'h1, 4'h0, 4'h0);
      tbl[19] = mk(1, 0, 4'h3, 4'h1, 4'h0, 4'h0);
      tbl[20] = mk(0, 0, 4'h3, 4'h1, 4'h0, 4'h0);
      tbl[21] = mk(1, 0, 4'h3, 4'h3, 4'h2, 4'h0);
      tbl[22] = mk(0, 0, 4'h3, 4'h3, 4'h0, 4'h0);
      tbl[23] = mk(1, 0, 4'hA, 4'h3, 4'h0, 4'h0);
      tbl[24] = mk(1, 0, 4'hA, 4'h3, 4'h0, 4'h0);
      tbl[25] = mk(1, 0, 4'hA, 4'hA, 4'h8, 4'h1);
      tbl[26] = mk(1, 0, 4'h3, 4'hA, 4'h0, 4'h0);
      tbl[27] = mk(1, 0, 4'h3, 4'hA, 4'h0, 4'h0);
      tbl[28] = mk(1, 0, 4'h3, 4'h3, 4'h1, 4'h8);
      tbl[29] = mk(1, 0, 4'hC, 4'h3, 4'h0, 4'h0);
      tbl[30] = mk(1, 0, 4'hC, 4'h3, 4'h0, 4'h0);
      tbl[31] = mk(1, 1, 4'hC, 4'h0, 4'h0, 4'h0);
      tbl[32] = mk(1, 0, 4'hC, 4'h0, 4'h0, 4'h0);
      tbl[33] = mk(1, 0, 4'hC, 4'h0, 4'h0, 4'h0);
      tbl[34] = mk(1, 0, 4'hC, 4'hC, 4'hC, 4'h0);

      // reset held with all inputs high
      rst_n = 1'b0; en = 1'b1; clr = 1'b0;
      i3 = 4'hF; i1 = 4'h0; i255 = 4'h0;
      #2;
      chk("rst_y_async", y3, 4'h0);
      step;
      step;
      chk("rst_y", y3, 4'h0);
      chk("rst_rise", rise3, 4'h0);
      chk("rst_fall", fall3, 4'h0);
      chk("rst_y_d1", y1, 4'h0);
      rst_n = 1'b1;

      for (int n = 0; n < NV; n++) begin
         en  = tbl[n].en;
         clr = tbl[n].clr;
         i3  = tbl[n].i;
         step;
         chk($sformatf("vec%0d_y", n), y3, tbl[n].y);
         chk($sformatf("vec%0d_rise", n), rise3, em(tbl[n].r));
         chk($sformatf("vec%0d_fall", n), fall3, em(tbl[n].f));
      end
      clr = 1'b0;
      en  = 1'b1;

      // async reset in the middle of a run (count at 2 of 3)
      i3 = 4'h3;
      step;
      step;
      chk("pre_rst_y", y3, 4'hC);
      #2 rst_n = 1'b0;
      #1 chk("midrun_rst_y", y3, 4'h0);
      chk("midrun_rst_rise", rise3, 4'h0);
      #1 rst_n = 1'b1;
      step;
      chk("post_rst_e1", y3, 4'h0);
      step;
      chk("post_rst_e2", y3, 4'h0);
      step;
      chk("post_rst_e3_y", y3, 4'h3);
      chk("post_rst_e3_rise", rise3, em(4'h3));
      chk("post_rst_e3_fall", fall3, 4'h0);

      // DEPTH=1: one enabled edge of delay
      i1 = 4'b1010;
      step;
      chk("d1_y_a", y1, 4'b1010);
      chk("d1_rise_a", rise1, em(4'b1010));
      i1 = 4'b0101;
      step;
      chk("d1_y_5", y1, 4'b0101);
      chk("d1_rise_5", rise1, em(4'b0101));
      chk("d1_fall_5", fall1, em(4'b1010));
      en = 1'b0; i1 = 4'hF;
      step;
      chk("d1_hold_y", y1, 4'b0101);
      chk("d1_hold_rise", rise1, 4'h0);
      en = 1'b1;
      step;
      chk("d1_y_f", y1, 4'hF);
      chk("d1_rise_f", rise1, em(4'b1010));
      chk("d1_fall_f", fall1, 4'h0);

      // DEPTH=255: no change after 254 samples, change on the 255th
      i255 = 4'h1;
      for (int n = 0; n < 254; n++) step;
      chk("d255_at254_y", y255, 4'h0);
      chk("d255_at254_rise", rise255, 4'h0);
      step;
      chk("d255_at255_y", y255, 4'h1);
      chk("d255_at255_rise", rise255, em(4'h1));
      step;
      chk("d255_pulse_end", rise255, 4'h0);
      chk("d255_hold_y", y255, 4'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
